// File: rtl/sb_cfg_pkg.sv
// Shared constants and width helpers for the switch-block configuration fabric.
package sb_cfg_pkg;

  localparam int SEL_PASS    = 0;
  localparam int SEL_TOP_PAD = 1;

  function automatic int sel_width(input int num_inpad);
    return $clog2(num_inpad + 1);
  endfunction

  function automatic int chain_length(input int chan_width, input int sel_w);
    return 2 * chan_width * sel_w;
  endfunction

endpackage

// File: rtl/sb_cfg_chain.sv
// Serial configuration chain with saturating bit counter and done flag.
// Optional shadow register for glitch-free reconfiguration: SB_CFG_SHADOW_EN.
module sb_cfg_chain
  import sb_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 96
) (
  input  logic                 prog_clk,
  input  logic                 prog_reset,
  input  logic                 ccff_head,
  input  logic                 ccff_en,
  input  logic                 cfg_commit,
  output logic [CHAIN_LEN-1:0] active_cfg,
  output logic                 cfg_valid,
  output logic                 cfg_done,
  output logic                 ccff_tail
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 done_q, done_d;

  always_comb begin
    cfg_d   = cfg_q;
    count_d = count_q;
    if (ccff_en) begin
      cfg_d = {cfg_q[CHAIN_LEN-2:0], ccff_head};
      if (count_q != CNT_W'(CHAIN_LEN)) begin
        count_d = count_q + 1'b1;
      end
    end
    done_d = (count_d == CNT_W'(CHAIN_LEN));
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      cfg_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign cfg_done  = done_q;
  assign ccff_tail = cfg_q[CHAIN_LEN-1];

`ifdef SB_CFG_SHADOW_EN
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic                 valid_q, valid_d;

  // Commit samples the chain as it stood before any shift on the same edge.
  always_comb begin
    shadow_d = shadow_q;
    valid_d  = valid_q;
    if (cfg_commit && done_q) begin
      shadow_d = cfg_q;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      shadow_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
    end
  end

  assign active_cfg = shadow_q;
  assign cfg_valid  = valid_q;
`else
  logic unused_commit;
  assign unused_commit = cfg_commit;
  assign active_cfg    = cfg_q;
  assign cfg_valid     = done_q;
`endif

endmodule

// File: rtl/sb_param_cfg.sv
// Parameterised switch block: routing muxes driven by the configuration chain.
// Optional shadow-register build selected with SB_CFG_SHADOW_EN.
module sb_param_cfg
  import sb_cfg_pkg::*;
#(
  parameter int CHAN_WIDTH = 12,
  parameter int NUM_INPAD  = 9
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  ccff_head,
  input  logic                  ccff_en,
  input  logic                  cfg_commit,
  input  logic [CHAN_WIDTH-1:0] chany_top_in,
  input  logic [CHAN_WIDTH-1:0] chanx_right_in,
  input  logic                  top_inpad,
  input  logic [NUM_INPAD-1:0]  right_inpad,
  output logic [CHAN_WIDTH-1:0] chany_top_out,
  output logic [CHAN_WIDTH-1:0] chanx_right_out,
  output logic                  ccff_tail,
  output logic                  cfg_done
);

  localparam int SEL_W     = sel_width(NUM_INPAD);
  localparam int CHAIN_LEN = chain_length(CHAN_WIDTH, SEL_W);
  localparam int NUM_CAND  = 2 ** SEL_W;

  logic [CHAIN_LEN-1:0] active_cfg;
  logic                 cfg_valid;

  sb_cfg_chain #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_chain (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .ccff_head  (ccff_head),
    .ccff_en    (ccff_en),
    .cfg_commit (cfg_commit),
    .active_cfg (active_cfg),
    .cfg_valid  (cfg_valid),
    .cfg_done   (cfg_done),
    .ccff_tail  (ccff_tail)
  );

  // Each track indexes a candidate vector covering every select code, so
  // unused codes land on a hard zero instead of a priority chain.
  genvar gi, gk;
  generate
    for (gi = 0; gi < CHAN_WIDTH; gi++) begin : g_top
      logic [SEL_W-1:0]    sel;
      logic [NUM_CAND-1:0] cand;
      assign sel = active_cfg[gi*SEL_W +: SEL_W];
      for (gk = 0; gk < NUM_CAND; gk++) begin : g_cand
        if (gk == SEL_PASS) begin : g_pass
          assign cand[gk] = chanx_right_in[(gi + 1) % CHAN_WIDTH];
        end else if (gk == SEL_TOP_PAD) begin : g_pad
          assign cand[gk] = top_inpad;
        end else begin : g_zero
          assign cand[gk] = 1'b0;
        end
      end
      assign chany_top_out[gi] = cfg_valid & cand[sel];
    end

    for (gi = 0; gi < CHAN_WIDTH; gi++) begin : g_right
      logic [SEL_W-1:0]    sel;
      logic [NUM_CAND-1:0] cand;
      assign sel = active_cfg[(CHAN_WIDTH + gi)*SEL_W +: SEL_W];
      for (gk = 0; gk < NUM_CAND; gk++) begin : g_cand
        if (gk == SEL_PASS) begin : g_pass
          assign cand[gk] = chany_top_in[(gi + CHAN_WIDTH - 1) % CHAN_WIDTH];
        end else if (gk <= NUM_INPAD) begin : g_pad
          assign cand[gk] = right_inpad[(gi + gk - 1) % NUM_INPAD];
        end else begin : g_zero
          assign cand[gk] = 1'b0;
        end
      end
      assign chanx_right_out[gi] = cfg_valid & cand[sel];
    end
  endgenerate

endmodule

// File: tb/tb_sb_param_cfg.sv
// Randomised self-checking bench for sb_param_cfg against a behavioural model.
// Build with +define+SB_CFG_SHADOW_EN to exercise the shadow-register variant.
module tb_sb_param_cfg;

  localparam int CW = 12;
  localparam int NI = 9;
  localparam int SW = 4;
  localparam int CL = 96;

  logic          prog_clk;
  logic          prog_reset;
  logic          ccff_head;
  logic          ccff_en;
  logic          cfg_commit;
  logic [CW-1:0] chany_top_in;
  logic [CW-1:0] chanx_right_in;
  logic          top_inpad;
  logic [NI-1:0] right_inpad;
  logic [CW-1:0] chany_top_out;
  logic [CW-1:0] chanx_right_out;
  logic          ccff_tail;
  logic          cfg_done;

  sb_param_cfg #(
    .CHAN_WIDTH (CW),
    .NUM_INPAD  (NI)
  ) dut (
    .prog_clk        (prog_clk),
    .prog_reset      (prog_reset),
    .ccff_head       (ccff_head),
    .ccff_en         (ccff_en),
    .cfg_commit      (cfg_commit),
    .chany_top_in    (chany_top_in),
    .chanx_right_in  (chanx_right_in),
    .top_inpad       (top_inpad),
    .right_inpad     (right_inpad),
    .chany_top_out   (chany_top_out),
    .chanx_right_out (chanx_right_out),
    .ccff_tail       (ccff_tail),
    .cfg_done        (cfg_done)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model state
  logic [CL-1:0] m_chain;
  int            m_count;
  bit            m_done;
`ifdef SB_CFG_SHADOW_EN
  logic [CL-1:0] m_shadow;
  bit            m_valid;
`endif
  bit            tail_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CL-1:0] act_vec();
`ifdef SB_CFG_SHADOW_EN
    return m_shadow;
`else
    return m_chain;
`endif
  endfunction

  function automatic bit act_valid();
`ifdef SB_CFG_SHADOW_EN
    return m_valid;
`else
    return m_done;
`endif
  endfunction

  function automatic int field_sel(input int f);
    logic [CL-1:0] v;
    v = act_vec() >> (f * SW);
    return int'(v[SW-1:0]);
  endfunction

  function automatic logic [CW-1:0] exp_top();
    logic [CW-1:0] r;
    logic [CW-1:0] t;
    r = '0;
    if (act_valid()) begin
      for (int i = 0; i < CW; i++) begin
        int s;
        s = field_sel(i);
        t = chanx_right_in >> ((i + 1) % CW);
        if (s == 0)      r[i] = t[0];
        else if (s == 1) r[i] = top_inpad;
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] exp_right();
    logic [CW-1:0] r;
    logic [CW-1:0] t;
    logic [NI-1:0] p;
    r = '0;
    if (act_valid()) begin
      for (int j = 0; j < CW; j++) begin
        int s;
        s = field_sel(CW + j);
        if (s == 0) begin
          t = chany_top_in >> ((j + CW - 1) % CW);
          r[j] = t[0];
        end else if (s <= NI) begin
          p = right_inpad >> ((j + s - 1) % NI);
          r[j] = p[0];
        end
      end
    end
    return r;
  endfunction

  task automatic model_clear();
    m_chain = '0;
    m_count = 0;
    m_done  = 0;
`ifdef SB_CFG_SHADOW_EN
    m_shadow = '0;
    m_valid  = 0;
`endif
  endtask

  task automatic model_edge(input bit en, input bit head, input bit commit);
    logic [CL-1:0] pre;
    bit            done_pre;
    pre      = m_chain;
    done_pre = m_done;
    if (en) begin
      m_chain = {m_chain[CL-2:0], head};
      if (m_count < CL) m_count++;
    end
    m_done = (m_count == CL);
`ifdef SB_CFG_SHADOW_EN
    if (commit && done_pre) begin
      m_shadow = pre;
      m_valid  = 1;
    end
`else
    if (commit && done_pre && pre[0]) begin
      // commit has no effect in this build
    end
`endif
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_top"},   64'(chany_top_out),   64'(exp_top()));
    check_val({tag, "_right"}, 64'(chanx_right_out), 64'(exp_right()));
    check_val({tag, "_done"},  64'(cfg_done),        64'(m_done));
    check_val({tag, "_tail"},  64'(ccff_tail),       64'(m_chain[CL-1]));
  endtask

  task automatic step(input bit en, input bit head, input bit commit);
    @(negedge prog_clk);
    ccff_en    = en;
    ccff_head  = head;
    cfg_commit = commit;
    @(posedge prog_clk);
    model_edge(en, head, commit);
    #1;
    ccff_en    = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic load_cfg(input logic [CL-1:0] v, input bit record);
    for (int k = CL - 1; k >= 0; k--) begin
      if (record) tail_q.push_back(v[k]);
      step(1'b1, v[k], 1'b0);
    end
  endtask

  task automatic commit_pulse();
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic randomize_inputs();
    chany_top_in   = CW'($urandom);
    chanx_right_in = CW'($urandom);
    top_inpad      = 1'($urandom);
    right_inpad    = NI'($urandom);
    #1;
  endtask

  // Asserted mid-cycle, away from any clock edge.
  task automatic async_reset(input string tag);
    #2;
    prog_reset = 1'b1;
    model_clear();
    #1;
    check_val({tag, "_top0"},  64'(chany_top_out),   64'(0));
    check_val({tag, "_right0"}, 64'(chanx_right_out), 64'(0));
    check_val({tag, "_done0"}, 64'(cfg_done),        64'(0));
    check_val({tag, "_tail0"}, 64'(ccff_tail),       64'(0));
    @(posedge prog_clk);
    @(negedge prog_clk);
    ccff_en    = 1'b0;
    cfg_commit = 1'b0;
    prog_reset = 1'b0;
    $display("[TB] reset %s", tag);
  endtask

  function automatic logic [CL-1:0] rand_cfg();
    logic [CL-1:0] v;
    for (int f = 0; f < 2 * CW; f++) v[f*SW +: SW] = SW'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    logic [CL-1:0] cfg_a;
    logic [CL-1:0] cfg_b;

    prog_reset     = 1'b1;
    ccff_head      = 1'b0;
    ccff_en        = 1'b0;
    cfg_commit     = 1'b0;
    chany_top_in   = '0;
    chanx_right_in = '0;
    top_inpad      = 1'b0;
    right_inpad    = '0;
    model_clear();
    repeat (2) @(posedge prog_clk);
    @(negedge prog_clk);
    prog_reset = 1'b0;

    // Unconfigured: everything reads zero regardless of inputs
    chanx_right_in = 12'hFFF;
    chany_top_in   = 12'hFFF;
    top_inpad      = 1'b1;
    right_inpad    = '1;
    #1;
    check_outputs("unconfigured");
    $display("[TB] unconfigured outputs checked");

    // 96 zeros: done only after the last one
    for (int k = 0; k < CL - 1; k++) step(1'b1, 1'b0, 1'b0);
    check_val("done_before_last", 64'(cfg_done), 64'(0));
    step(1'b1, 1'b0, 1'b0);
    check_val("done_after_last", 64'(cfg_done), 64'(1));
    if (act_valid() == 0) commit_pulse();
    for (int r = 0; r < 3; r++) begin
      randomize_inputs();
      check_outputs("pass_all");
      check_val("pass_top_rot", 64'(chany_top_out), 64'({chanx_right_in[0], chanx_right_in[CW-1:1]}));
      check_val("pass_r0", 64'(chanx_right_out[0]), 64'(chany_top_in[CW-1]));
    end
    $display("[TB] all-pass configuration checked");

    // Right track 0 pad select, then an out-of-range select
    cfg_a = '0;
    cfg_a[CW*SW +: SW] = 4'd3;
    load_cfg(cfg_a, 1'b0);
    commit_pulse();
    right_inpad = 9'b000000100;
    #1;
    check_val("r0_sel3", 64'(chanx_right_out[0]), 64'(1));
    check_outputs("r0_sel3_all");
    cfg_a[CW*SW +: SW] = 4'd12;
    load_cfg(cfg_a, 1'b0);
    commit_pulse();
    #1;
    check_val("r0_sel12", 64'(chanx_right_out[0]), 64'(0));
    check_outputs("r0_sel12_all");
    $display("[TB] right pad select boundary checked");

    // Random configurations and inputs
    for (int n = 0; n < 6; n++) begin
      load_cfg(rand_cfg(), 1'b0);
      commit_pulse();
      for (int r = 0; r < 3; r++) begin
        randomize_inputs();
        check_outputs("rand");
      end
      $display("[TB] random configuration %0d checked", n);
    end

    // Chain pass-through: the first pattern emerges at the tail in order
    tail_q.delete();
    cfg_a = rand_cfg();
    cfg_b = rand_cfg();
    load_cfg(cfg_a, 1'b1);
    for (int k = CL - 1; k >= 0; k--) begin
      bit b;
      b = tail_q.pop_front();
      check_val("tail_order", 64'(ccff_tail), 64'(b));
      step(1'b1, cfg_b[k], 1'b0);
    end
    check_val("done_hold", 64'(cfg_done), 64'(1));
    check_outputs("after_stream");
    $display("[TB] tail stream checked");

    // Reset after 40 shifts, then mid-shift reset with ccff_en high
    for (int k = 0; k < 40; k++) step(1'b1, 1'($urandom), 1'b0);
    async_reset("after40");
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0);
    @(negedge prog_clk);
    ccff_en   = 1'b1;
    ccff_head = 1'b1;
    async_reset("midshift");
    for (int k = 0; k < CL - 1; k++) step(1'b1, 1'($urandom), 1'b0);
    check_val("reload_95", 64'(cfg_done), 64'(0));
    step(1'b1, 1'b0, 1'b0);
    check_val("reload_96", 64'(cfg_done), 64'(1));
    randomize_inputs();
    check_outputs("reload");

    // Commit sequencing: A committed, B shifted, then committed
    cfg_a = rand_cfg();
    cfg_b = rand_cfg();
    load_cfg(cfg_a, 1'b0);
    commit_pulse();
    randomize_inputs();
    check_outputs("cfg_a");
    load_cfg(cfg_b, 1'b0);
    randomize_inputs();
    check_outputs("cfg_b_pending");
    commit_pulse();
    randomize_inputs();
    check_outputs("cfg_b_live");
    $display("[TB] commit sequencing checked");

    // Early commit is ignored; commit with a shift captures the pre-shift chain
    async_reset("early");
    for (int k = 0; k < 50; k++) step(1'b1, 1'($urandom), 1'b0);
    commit_pulse();
    randomize_inputs();
    check_outputs("early_commit");
    for (int k = 0; k < CL - 50; k++) step(1'b1, 1'($urandom), 1'b0);
    step(1'b1, 1'($urandom), 1'b1);
    randomize_inputs();
    check_outputs("commit_with_shift");
    $display("[TB] early and concurrent commit checked");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
